// File: rtl/classifier_cfg_ctrl_if.sv
// Byte-wide configuration write channel of the classifier controller.
// The master drives write requests; the slave answers with cfg_ready.
interface classifier_cfg_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/classifier_cfg_ctrl.sv
// Configuration and sequencing controller in front of the seizure-event
// classifier. Register writes land in shadow registers; a validated commit
// copies them into the active set only while the classifier reports class C
// (or immediately when forced), then holds the classifier in restart for
// RESTART_CYCLES cycles with detections gated. A small monitor flags
// class changes and counts entries into class A.
module classifier_cfg_ctrl #(
    parameter int unsigned RESTART_CYCLES  = 4,
    parameter logic [7:0]  A_DEFAULT       = 8'd5,
    parameter logic [7:0]  B_DEFAULT       = 8'd1,
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'd10000
) (
    input  logic                        clk,
    input  logic                        reset,
    classifier_cfg_ctrl_if.slave        cfg,
    input  logic [1:0]                  event_in,
    input  logic                        detection_in,
    output logic                        detection_out,
    output logic [7:0]                  class_a_thresh_out,
    output logic [7:0]                  class_b_thresh_out,
    output logic [15:0]                 timeout_period_out,
    output logic                        clf_reset,
    output logic                        busy,
    output logic                        pending,
    output logic                        cfg_error,
    output logic                        event_change,
    output logic [7:0]                  a_entry_count
);

    localparam logic [1:0] EV_C = 2'b00;
    localparam logic [1:0] EV_A = 2'b10;

    // Down-counter covers RESTART_CYCLES-1 cycles of the RESTART state.
    localparam int unsigned CNT_W = (RESTART_CYCLES > 2) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2,
        RESTART = 2'd3
    } state_t;

    // Saturating increment used by the class-A entry counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]       shd_a_q,  shd_a_d;
    logic [7:0]       shd_b_q,  shd_b_d;
    logic [15:0]      shd_t_q,  shd_t_d;
    logic [7:0]       act_a_q,  act_a_d;
    logic [7:0]       act_b_q,  act_b_d;
    logic [15:0]      act_t_q,  act_t_d;
    logic             err_q,    err_d;
    logic [1:0]       prev_ev_q, prev_ev_d;
    logic             evchg_q,  evchg_d;
    logic [7:0]       acnt_q,   acnt_d;

    logic wr_en;
    logic commit_ok;
    logic err_set;
    logic err_clr;
    logic acnt_clr;
    logic a_entry;

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign pending       = (state_q == PENDING);
    assign clf_reset     = (state_q == APPLY) || (state_q == RESTART);
    assign detection_out = detection_in & ~clf_reset;

    assign class_a_thresh_out = act_a_q;
    assign class_b_thresh_out = act_b_q;
    assign timeout_period_out = act_t_q;
    assign cfg_error          = err_q;
    assign event_change       = evchg_q;
    assign a_entry_count      = acnt_q;

    assign wr_en     = cfg.cfg_valid && cfg.cfg_ready;
    assign commit_ok = (shd_a_q > shd_b_q) && (shd_b_q != 8'd0) && (shd_t_q != 16'd0);

    // Sequencer next state: register writes, commit validation, apply and restart timing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shd_a_d  = shd_a_q;
        shd_b_d  = shd_b_q;
        shd_t_d  = shd_t_q;
        act_a_d  = act_a_q;
        act_b_d  = act_b_q;
        act_t_d  = act_t_q;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        acnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    case (cfg.cfg_addr)
                        3'd0: shd_a_d = cfg.cfg_data;
                        3'd1: shd_b_d = cfg.cfg_data;
                        3'd2: shd_t_d[7:0]  = cfg.cfg_data;
                        3'd3: shd_t_d[15:8] = cfg.cfg_data;
                        3'd4: begin
                            if (commit_ok) begin
                                state_d = (cfg.cfg_data[0] || (event_in == EV_C)) ? APPLY : PENDING;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        3'd5: begin
                            err_clr  = cfg.cfg_data[0];
                            acnt_clr = cfg.cfg_data[1];
                        end
                        default: ;
                    endcase
                end
            end
            PENDING: begin
                // Wait indefinitely for a quiet classifier before swapping thresholds.
                if (event_in == EV_C) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                act_a_d = shd_a_q;
                act_b_d = shd_b_q;
                act_t_d = shd_t_q;
                if (RESTART_CYCLES > 1) begin
                    state_d = RESTART;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            RESTART: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A rejected commit outranks a clear landing on the same edge.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Event monitor next state: change pulse, previous code and class-A entry count.
    always_comb begin
        a_entry = (event_in == EV_A) && (prev_ev_q != EV_A) && !clf_reset;
        if (clf_reset) begin
            evchg_d   = 1'b0;
            prev_ev_d = EV_C;
        end else begin
            evchg_d   = (event_in != prev_ev_q);
            prev_ev_d = event_in;
        end
        if (acnt_clr) begin
            acnt_d = 8'd0;
        end else if (a_entry) begin
            acnt_d = sat_inc8(acnt_q);
        end else begin
            acnt_d = acnt_q;
        end
    end

    // Sequencer state and configuration registers; reset aborts any apply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shd_a_q <= A_DEFAULT;
            shd_b_q <= B_DEFAULT;
            shd_t_q <= TIMEOUT_DEFAULT;
            act_a_q <= A_DEFAULT;
            act_b_q <= B_DEFAULT;
            act_t_q <= TIMEOUT_DEFAULT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shd_a_q <= shd_a_d;
            shd_b_q <= shd_b_d;
            shd_t_q <= shd_t_d;
            act_a_q <= act_a_d;
            act_b_q <= act_b_d;
            act_t_q <= act_t_d;
            err_q   <= err_d;
        end
    end

    // Event monitor registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ev_q <= EV_C;
            evchg_q   <= 1'b0;
            acnt_q    <= 8'd0;
        end else begin
            prev_ev_q <= prev_ev_d;
            evchg_q   <= evchg_d;
            acnt_q    <= acnt_d;
        end
    end

endmodule
